ascii_uart_tx: RTL and testbench
================================

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter APPEND_CRLF, default 1; when 1, CR (8'h0D) then LF (8'h0A) follow the 7 characters.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ascii_in  input  56  seven ASCII characters; char k occupies [(k*8)+:8], k=0..6 (bit-k character of the binary-to-ASCII stage).
REQ-006 SHALL have port send  input  1  request to transmit ascii_in; sampled only when ready=1.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept send.
REQ-008 SHALL have port busy  output  1  high while any frame is in progress; always equals ~ready.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the last frame's stop bit completes.
REQ-010 SHALL have port tx  output  1  UART 8N1 serial line, idle high, registered output.

Function
REQ-011 SHALL capture ascii_in into an internal 56-bit buffer on the rising edge where send=1 and ready=1; later ascii_in changes SHALL NOT affect the transmission.
REQ-012 SHALL ignore send while busy=1; no queuing, no restart.
REQ-013 SHALL transmit characters in order k=6,5,...,0 (MSB character first), then CR, LF when APPEND_CRLF=1; frame count 9 or 7.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP: IDLE->START on accepted send; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->START if frames remain, else STOP->IDLE.
REQ-015 SHALL drive each frame as: start bit 0, 8 data bits LSB first, stop bit 1, each held exactly CLKS_PER_BIT cycles; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-016 SHALL drive tx=0 starting in the cycle immediately after the accepting edge (one-cycle latency).
REQ-017 SHALL send frames back-to-back with no idle gap between a stop bit and the next start bit.
REQ-018 SHALL use a baud counter of width ceil(log2(CLKS_PER_BIT)) and count 0..CLKS_PER_BIT-1 with wrap to 0; a 3-bit bit index; a 4-bit frame index.
REQ-019 SHALL assert done for exactly one cycle, in the first cycle after the final stop bit, with ready=1 in that same cycle.
REQ-020 SHALL accept a send asserted during the done cycle, since ready=1 then; the next start bit begins one cycle later.
REQ-021 SHALL hold tx=1 in IDLE.

Reset
REQ-022 SHALL, on rst_n=0, immediately (asynchronously) force state=IDLE, tx=1, ready=1, busy=0, done=0, and clear all counters and the buffer to 0.
REQ-023 SHALL abort any in-progress frame on reset without emitting done; after rst_n rises, the first rising edge with send=1 starts a fresh transmission.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-024 SHALL cover: ascii_in = "1010011" (bytes k6..k0 = 31,30,31,30,30,31,31), pulse send -> tx shows frames 31,30,31,30,30,31,31,0D,0A LSB-first; done occurs 360 cycles after tx falls.
REQ-025 SHALL cover: APPEND_CRLF=0, same stimulus -> 7 frames only; done occurs 280 cycles after tx falls.
REQ-026 SHALL cover: send re-pulsed with new ascii_in at cycle 50 of a transmission -> ignored; the output bytes are unchanged and done still occurs at cycle 360.
REQ-027 SHALL cover: rst_n=0 during the third frame -> tx=1, ready=1 in the same cycle; no done pulse; a subsequent send produces a full, correct 9-frame sequence.
REQ-028 SHALL cover: send held high continuously -> a second transmission starts one cycle after done, with no gap beyond that single idle-high cycle.
REQ-029 SHALL cover: CLKS_PER_BIT=2, ascii_in all 8'h30 -> each bit lasts exactly 2 cycles; a checker samples at mid-bit with no framing error.

Source files
------------

// File: rtl/ascii_uart_tx.sv
// Serialises a captured 7-character ASCII word (optionally followed by CR, LF)
// as back-to-back UART 8N1 frames, most significant character first.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int APPEND_CRLF  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [55:0] ascii_in,
    input  logic        send,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        tx,
    output logic [1:0]  state_dbg_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_FRAME = (APPEND_CRLF != 0) ? 4'd8 : 4'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: a transmission is accepted on the rising edge where send=1
    // and ready=1; while busy=1 send is ignored entirely.
    state_t          state_q;
    logic [55:0]     buf_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [3:0]      frame_q;
    logic            tx_q;
    logic            ready_q;
    logic            done_q;
    logic [7:0]      cur_byte;

    always_comb begin
        cur_byte = 8'h00;
        case (frame_q)
            4'd0:    cur_byte = buf_q[55:48];
            4'd1:    cur_byte = buf_q[47:40];
            4'd2:    cur_byte = buf_q[39:32];
            4'd3:    cur_byte = buf_q[31:24];
            4'd4:    cur_byte = buf_q[23:16];
            4'd5:    cur_byte = buf_q[15:8];
            4'd6:    cur_byte = buf_q[7:0];
            4'd7:    cur_byte = 8'h0D;
            4'd8:    cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (send) begin
                        buf_q   <= ascii_in;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        frame_q <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= cur_byte[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_byte[bit_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        // Next start bit follows the stop bit with no idle gap.
                        if (frame_q == LAST_FRAME) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            frame_q <= frame_q + 4'd1;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = ready_q;
    assign busy        = ~ready_q;
    assign done        = done_q;
    assign tx          = tx_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Bench for ascii_uart_tx: three instances (4 clk/bit with and without CR/LF,
// 2 clk/bit) compared cycle by cycle against an expected serial bit stream.
module tb_ascii_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  send_v = 3'b000;
    logic [55:0] ascii_v [3];
    logic [2:0]  tx_w, done_w, ready_w, busy_w;
    logic [1:0]  state_w [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ascii_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ascii_in(ascii_v[0]), .send(send_v[0]),
        .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0]),
        .state_dbg_o(state_w[0]));

    ascii_uart_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ascii_in(ascii_v[1]), .send(send_v[1]),
        .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1]),
        .state_dbg_o(state_w[1]));

    ascii_uart_tx #(.CLKS_PER_BIT(2), .APPEND_CRLF(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ascii_in(ascii_v[2]), .send(send_v[2]),
        .ready(ready_w[2]), .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2]),
        .state_dbg_o(state_w[2]));

    localparam logic [55:0] DIGITS = {8'h31, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31, 8'h31};

    function automatic logic [55:0] rand_chars();
        logic [55:0] r;
        for (int k = 0; k < 7; k++) r[k*8 +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    // Called at the falling edge of the first cycle after the accepting edge.
    // Walks the expected line level for every cycle of every frame, then
    // checks the done cycle. Optionally re-pulses send mid-transmission.
    task automatic check_stream(input int d, input int cpb, input logic [55:0] chars,
                                input bit crlf, input int repulse_at);
        logic [0:0] exp_q[$];
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [0:0] e;
        int         i;
        for (int k = 6; k >= 0; k--) bytes.push_back(chars[k*8 +: 8]);
        if (crlf) begin
            bytes.push_back(8'h0D);
            bytes.push_back(8'h0A);
        end
        foreach (bytes[f]) begin
            b = bytes[f];
            repeat (cpb) exp_q.push_back(1'b0);
            for (int n = 0; n < 8; n++) repeat (cpb) exp_q.push_back(b[n]);
            repeat (cpb) exp_q.push_back(1'b1);
        end
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (tx_w[d] !== e[0]) begin
                miscompares++;
                $display("FAIL tx_level dut%0d cycle %0d: got %b expected %b", d, i, tx_w[d], e[0]);
            end
            vectors++;
            if (done_w[d] !== 1'b0 || ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_flags dut%0d cycle %0d: got done=%b ready=%b busy=%b expected 0/0/1",
                         d, i, done_w[d], ready_w[d], busy_w[d]);
            end
            if (repulse_at >= 0 && i == repulse_at) begin
                ascii_v[d] = rand_chars();
                send_v[d]  = 1'b1;
            end
            if (repulse_at >= 0 && i == repulse_at + 1) send_v[d] = 1'b0;
            i++;
            @(negedge clk);
        end
        vectors++;
        if (done_w[d] !== 1'b1 || ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || tx_w[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL done_cycle dut%0d at cycle %0d: got done=%b ready=%b busy=%b tx=%b expected 1/1/0/1",
                     d, i, done_w[d], ready_w[d], busy_w[d], tx_w[d]);
        end
    endtask

    task automatic send_and_check(input int d, input int cpb, input logic [55:0] chars,
                                  input bit crlf, input int repulse_at);
        vectors++;
        if (ready_w[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_send dut%0d: got %b expected 1", d, ready_w[d]);
        end
        ascii_v[d] = chars;
        send_v[d]  = 1'b1;
        @(negedge clk);
        send_v[d]  = 1'b0;
        ascii_v[d] = rand_chars();
        check_stream(d, cpb, chars, crlf, repulse_at);
        @(negedge clk);
        vectors++;
        if (done_w[d] !== 1'b0 || tx_w[d] !== 1'b1 || ready_w[d] !== 1'b1) begin
            miscompares++;
            $display("FAIL after_done dut%0d: got done=%b tx=%b ready=%b expected 0/1/1",
                     d, done_w[d], tx_w[d], ready_w[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (tx_w[d] !== 1'b1 || ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got tx=%b ready=%b busy=%b done=%b expected 1/1/0/0",
                         d, tx_w[d], ready_w[d], busy_w[d], done_w[d]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (tx_w[d] !== 1'b1 || ready_w[d] !== 1'b1 || done_w[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset dut%0d: got tx=%b ready=%b done=%b expected 1/1/0",
                         d, tx_w[d], ready_w[d], done_w[d]);
            end
        end
    endtask

    task automatic test_digits();
        send_and_check(0, 4, DIGITS, 1'b1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_and_check(0, 4, rand_chars(), 1'b1, -1);
        end
    endtask

    task automatic test_no_crlf();
        send_and_check(1, 4, DIGITS, 1'b0, -1);
        send_and_check(1, 4, rand_chars(), 1'b0, -1);
    endtask

    task automatic test_ignore_send();
        send_and_check(0, 4, DIGITS, 1'b1, 50);
        send_and_check(0, 4, rand_chars(), 1'b1, 50);
    endtask

    task automatic test_reset_abort();
        ascii_v[0] = rand_chars();
        send_v[0]  = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        repeat (90) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got tx=%b ready=%b busy=%b done=%b expected 1/1/0/0",
                     tx_w[0], ready_w[0], busy_w[0], done_w[0]);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vectors++;
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got done=%b tx=%b expected 0/1", n, done_w[0], tx_w[0]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_and_check(0, 4, DIGITS, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        logic [55:0] first_c, second_c;
        first_c    = rand_chars();
        second_c   = rand_chars();
        ascii_v[0] = first_c;
        send_v[0]  = 1'b1;
        @(negedge clk);
        check_stream(0, 4, first_c, 1'b1, -1);
        ascii_v[0] = second_c;
        @(negedge clk);
        check_stream(0, 4, second_c, 1'b1, -1);
        send_v[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_end: got done=%b tx=%b ready=%b expected 0/1/1",
                     done_w[0], tx_w[0], ready_w[0]);
        end
    endtask

    task automatic test_fast_baud();
        send_and_check(2, 2, {7{8'h30}}, 1'b1, -1);
        send_and_check(2, 2, rand_chars(), 1'b1, -1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) ascii_v[d] = '0;
        test_reset();
        test_digits();
        test_random();
        test_no_crlf();
        test_ignore_send();
        test_reset_abort();
        test_back_to_back();
        test_fast_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
